// File: rtl/sr_pkg.sv
// Shared definitions for the diad special-register file.
// Index map, default stack bounds and request bundle.
package sr_pkg;

    localparam int SR_FLAGS = 0;
    localparam int SR_SSP   = 1;
    localparam int SR_USP   = 2;
    localparam int SR_EPC   = 3;

    localparam logic [23:0] SSP_RST_D = 24'h000FFF;
    localparam logic [23:0] STK_LO_D  = 24'h000000;
    localparam logic [23:0] STK_HI_D  = 24'h000FFF;

    typedef struct packed {
        logic wr;
        logic push;
        logic pop;
        logic swap;
    } sr_req_t;

endpackage

// File: rtl/sr_stack_adj.sv
// Next-SSP computation for push/pop with bounds check.
// Purely combinational, one guard bit for borrow/carry.
module sr_stack_adj #(
    parameter int                 DATA_W   = 24,
    parameter int                 STK_STEP = 3,
    parameter logic [DATA_W-1:0] STK_LO   = '0,
    parameter logic [DATA_W-1:0] STK_HI   = '1
) (
    input  logic [DATA_W-1:0] iw_ssp,
    input  logic              iw_push,
    input  logic              iw_pop,
    output logic [DATA_W-1:0] ow_nxt_ssp,
    output logic              ow_ovf,
    output logic              ow_unf
);

    localparam logic [DATA_W:0] STEP = (DATA_W+1)'(STK_STEP);

    logic [DATA_W:0] diff;
    logic [DATA_W:0] sum;
    logic            below;
    logic            above;

    assign diff = {1'b0, iw_ssp} - STEP;
    assign sum  = {1'b0, iw_ssp} + STEP;

    // A zero floor only trips on borrow
    if (STK_LO == '0) begin : g_lo0
        assign below = diff[DATA_W];
    end else begin : g_lo
        assign below = diff[DATA_W] | (diff[DATA_W-1:0] < STK_LO);
    end

    // An all-ones ceiling only trips on carry
    if (STK_HI == '1) begin : g_hi1
        assign above = sum[DATA_W];
    end else begin : g_hi
        assign above = sum[DATA_W] | (sum[DATA_W-1:0] > STK_HI);
    end

    // Select adjusted SSP; simultaneous push and pop cancel
    always_comb begin
        ow_nxt_ssp = iw_ssp;
        ow_ovf     = 1'b0;
        ow_unf     = 1'b0;
        unique case (1'b1)
            (iw_push && !iw_pop): begin
                ow_ovf = below;
                if (!below) ow_nxt_ssp = diff[DATA_W-1:0];
            end
            (iw_pop && !iw_push): begin
                ow_unf = above;
                if (!above) ow_nxt_ssp = sum[DATA_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/regsr_bank.sv
// Banked special-register file with SSP adjust and write lock.
// Swap beats write beats adjust within a cycle.
module regsr_bank
    import sr_pkg::*;
#(
    parameter int                 DATA_W    = 24,
    parameter int                 NUM_SR    = 16,
    parameter int                 NUM_RD    = 2,
    parameter int                 SSP_IDX   = SR_SSP,
    parameter logic [DATA_W-1:0] SSP_RST   = DATA_W'(SSP_RST_D),
    parameter int                 STK_STEP  = 3,
    parameter logic [DATA_W-1:0] STK_LO    = DATA_W'(STK_LO_D),
    parameter logic [DATA_W-1:0] STK_HI    = DATA_W'(STK_HI_D),
    parameter logic [NUM_SR-1:0] LOCK_MASK = NUM_SR'(16'h0002),
    parameter bit                 BYPASS    = 1'b1,
    localparam int                AW        = $clog2(NUM_SR)
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst_n,
    input  logic [NUM_RD*AW-1:0]     iw_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] ow_rd_data,
    input  logic [AW-1:0]            iw_wr_addr,
    input  logic [DATA_W-1:0]        iw_wr_data,
    input  logic                     iw_wr_en,
    input  logic                     iw_priv,
    input  logic                     iw_stk_push,
    input  logic                     iw_stk_pop,
    input  logic                     iw_bank_swap,
    input  logic                     iw_flt_clr,
    output logic [DATA_W-1:0]        ow_ssp,
    output logic                     ow_bank,
    output logic                     ow_ovf,
    output logic                     ow_unf,
    output logic                     ow_wr_fault
);

    localparam logic [AW-1:0] SSP_A = AW'(SSP_IDX);

    logic [DATA_W-1:0] act [NUM_SR];
    logic [DATA_W-1:0] shd [NUM_SR];

    logic              wr_ok;
    logic              wr_lock;
    logic              adj_en;
    sr_req_t           req;
    logic [DATA_W-1:0] nxt_ssp;
    logic              ovf_s;
    logic              unf_s;
    logic [AW-1:0]     ra;

    assign ow_ssp = act[SSP_A];

    // Resolve the cycle's request against lock and priority
    always_comb begin
        wr_ok    = iw_wr_en & (~LOCK_MASK[iw_wr_addr] | iw_priv);
        wr_lock  = iw_wr_en & ~wr_ok & ~iw_bank_swap;
        adj_en   = ~iw_bank_swap & ~(wr_ok & (iw_wr_addr == SSP_A));
        req.swap = iw_bank_swap;
        req.wr   = wr_ok & ~iw_bank_swap;
        req.push = iw_stk_push & adj_en;
        req.pop  = iw_stk_pop & adj_en;
    end

    sr_stack_adj #(
        .DATA_W   (DATA_W),
        .STK_STEP (STK_STEP),
        .STK_LO   (STK_LO),
        .STK_HI   (STK_HI)
    ) u_adj (
        .iw_ssp     (act[SSP_A]),
        .iw_push    (req.push),
        .iw_pop     (req.pop),
        .ow_nxt_ssp (nxt_ssp),
        .ow_ovf     (ovf_s),
        .ow_unf     (unf_s)
    );

    // Read ports with optional same-cycle write forwarding
    always_comb begin
        ow_rd_data = '0;
        ra         = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = iw_rd_addr[p*AW +: AW];
            if (BYPASS && req.wr && (iw_wr_addr == ra))
                ow_rd_data[p*DATA_W +: DATA_W] = iw_wr_data;
            else
                ow_rd_data[p*DATA_W +: DATA_W] = act[ra];
        end
    end

    // Bank storage: swap, else adjust then write
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            for (int i = 0; i < NUM_SR; i++) begin
                act[i] <= (i == SSP_IDX) ? SSP_RST : '0;
                shd[i] <= (i == SSP_IDX) ? SSP_RST : '0;
            end
            ow_bank <= 1'b0;
        end else if (req.swap) begin
            for (int i = 0; i < NUM_SR; i++) begin
                act[i] <= shd[i];
                shd[i] <= act[i];
            end
            ow_bank <= ~ow_bank;
        end else begin
            act[SSP_A] <= nxt_ssp;
            if (req.wr) act[iw_wr_addr] <= iw_wr_data;
        end
    end

    // Sticky stack faults and one-shot lock fault
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            ow_ovf      <= 1'b0;
            ow_unf      <= 1'b0;
            ow_wr_fault <= 1'b0;
        end else begin
            ow_ovf      <= (ow_ovf & ~iw_flt_clr) | ovf_s;
            ow_unf      <= (ow_unf & ~iw_flt_clr) | unf_s;
            ow_wr_fault <= wr_lock;
        end
    end

endmodule
